// File: rtl/rv32e_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-outstanding memory bus.
// Alternating priority on contention, with a response timeout.
module rv32e_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic        f_err,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_d;
    logic        sel_d;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [CW-1:0] cnt;

    logic        any_req;
    logic        win_d;
    logic        tmo_hit;
    logic        resp;
    logic        tmo;
    logic        gnt;

    // Data wins unless fetch is also asking and data was granted last.
    assign any_req = f_req | d_req;
    assign win_d   = d_req & (~f_req | ~last_d);
    assign tmo_hit = (cnt == CW'(TIMEOUT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, memory request drive and grant/response decisions.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_be    = 4'h0;
        gnt       = 1'b0;
        resp      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = REQ;
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                mem_be    = lat_be;
                // A same-cycle response beats the timeout; a bare
                // grant at the timeout cycle is dropped.
                if (mem_gnt && mem_rvalid) begin
                    gnt       = 1'b1;
                    resp      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end else if (mem_gnt) begin
                    gnt       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign f_gnt = gnt & ~sel_d;
    assign d_gnt = gnt & sel_d;

    // Timeout counter: zero while idle, counts through REQ and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (state == IDLE) cnt <= '0;
        else                    cnt <= cnt + CW'(1);
    end

    // Latch the winner's request and record who was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d    <= 1'b0;
            sel_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
        end else if (state == IDLE && any_req) begin
            last_d    <= win_d;
            sel_d     <= win_d;
            lat_we    <= win_d & d_we;
            lat_addr  <= win_d ? d_addr : f_addr;
            lat_wdata <= win_d ? d_wdata : 32'h0;
            lat_be    <= win_d ? d_be : 4'hF;
        end
    end

    // Registered response pulses; writes and timeouts return zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            f_rdata  <= 32'h0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= 32'h0;
        end else begin
            f_rvalid <= 1'b0;
            f_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            if (resp || tmo) begin
                if (sel_d) begin
                    d_rvalid <= 1'b1;
                    d_err    <= tmo;
                    d_rdata  <= (tmo || lat_we) ? 32'h0 : mem_rdata;
                end else begin
                    f_rvalid <= 1'b1;
                    f_err    <= tmo;
                    f_rdata  <= tmo ? 32'h0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed bench for rv32e_mem_arbiter (TIMEOUT=4).
// Inputs change and outputs are sampled just after the falling edge.
module tb_rv32e_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt, f_rvalid, f_err;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_be = 4'h0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rv32e_mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .f_err(f_err), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        f_req = 1'b1; d_req = 1'b1;
        f_addr = 32'h10; d_addr = 32'h20;
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        nx(); nx();
        vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 70'h0) begin
            errs++;
            $display("FAIL reset_mem: got req=%b addr=%h want 0", mem_req, mem_addr);
        end
        vec++;
        if ({f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err} !== 6'h0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 0",
                     {f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err});
        end
        vec++;
        if ({f_rdata, d_rdata} !== 64'h0) begin
            errs++;
            $display("FAIL reset_rdata: got %h %h want 0", f_rdata, d_rdata);
        end
        rst = 1'b0;
    endtask

    // Both held high, zero-latency memory: D,F,D,F every 2 cycles.
    task automatic test_contention();
        logic eg_d, eg_f, ev_d, ev_f;
        logic [31:0] exp_rd;
        for (int i = 1; i <= 8; i++) begin
            nx();
            mem_rdata = 32'hA0 + i;
            exp_rd = 32'hA0 + i - 1;
            eg_d = (i % 4 == 1);
            eg_f = (i % 4 == 3);
            ev_d = (i % 4 == 2);
            ev_f = (i % 4 == 0);
            vec++;
            if ({d_gnt, f_gnt} !== {eg_d, eg_f}) begin
                errs++;
                $display("FAIL cont_gnt[%0d]: got d=%b f=%b want d=%b f=%b",
                         i, d_gnt, f_gnt, eg_d, eg_f);
            end
            vec++;
            if ({d_rvalid, f_rvalid} !== {ev_d, ev_f}) begin
                errs++;
                $display("FAIL cont_rvalid[%0d]: got d=%b f=%b want d=%b f=%b",
                         i, d_rvalid, f_rvalid, ev_d, ev_f);
            end
            if (ev_d) begin
                vec++;
                if (d_rdata !== exp_rd) begin
                    errs++;
                    $display("FAIL cont_drdata[%0d]: got %h want %h", i, d_rdata, exp_rd);
                end
            end
            if (ev_f) begin
                vec++;
                if (f_rdata !== exp_rd || d_rdata !== exp_rd - 2) begin
                    errs++;
                    $display("FAIL cont_frdata[%0d]: got f=%h d=%h want f=%h d=%h",
                             i, f_rdata, d_rdata, exp_rd, exp_rd - 2);
                end
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        nx();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
        d_wdata = 32'hCAFEF00D; d_be = 4'b0011;
        nx();
        vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !==
            {2'b11, 32'h200, 32'hCAFEF00D, 4'b0011}) begin
            errs++;
            $display("FAIL wr_mem: got req=%b we=%b a=%h wd=%h be=%b want 1 1 200 cafef00d 0011",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        mem_gnt = 1'b1;
        #1;
        vec++;
        if ({d_gnt, f_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL wr_gnt: got d=%b f=%b want d=1 f=0", d_gnt, f_gnt);
        end
        nx();
        mem_gnt = 1'b0; d_req = 1'b0; d_we = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        nx();
        mem_rvalid = 1'b0;
        vec++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin
            errs++;
            $display("FAIL wr_ack: got v=%b e=%b rd=%h want 1 0 0", d_rvalid, d_err, d_rdata);
        end
        vec++;
        if (f_rvalid !== 1'b0 || f_rdata !== 32'hA7) begin
            errs++;
            $display("FAIL wr_fhold: got v=%b rd=%h want 0 a7", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_single_fetch();
        f_req = 1'b1; f_addr = 32'h100; d_wdata = 32'h12345678;
        nx();
        vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, f_gnt} !==
            {2'b10, 32'h100, 32'h0, 4'hF, 1'b0}) begin
            errs++;
            $display("FAIL fetch_mem: got req=%b we=%b a=%h wd=%h be=%h want 1 0 100 0 f",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        nx();
        mem_gnt = 1'b1;
        #1;
        vec++;
        if ({f_gnt, d_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL fetch_gnt: got f=%b d=%b want f=1 d=0", f_gnt, d_gnt);
        end
        nx();
        mem_gnt = 1'b0; f_req = 1'b0;
        vec++;
        if ({mem_req, f_gnt, f_rvalid} !== 3'b000) begin
            errs++;
            $display("FAIL fetch_resp_state: got req=%b gnt=%b v=%b want 000",
                     mem_req, f_gnt, f_rvalid);
        end
        nx();
        mem_rvalid = 1'b1; mem_rdata = 32'h00A00093;
        nx();
        mem_rvalid = 1'b0;
        vec++;
        if ({f_rvalid, f_err, f_rdata, d_rvalid} !== {2'b10, 32'h00A00093, 1'b0}) begin
            errs++;
            $display("FAIL fetch_resp: got v=%b e=%b rd=%h dv=%b want 1 0 00a00093 0",
                     f_rvalid, f_err, f_rdata, d_rvalid);
        end
        nx();
        vec++;
        if (f_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL fetch_pulse: got v=%b want 0", f_rvalid);
        end
    endtask

    task automatic test_timeout();
        f_req = 1'b1; f_addr = 32'h300;
        nx();
        mem_gnt = 1'b1;
        #1;
        vec++;
        if (f_gnt !== 1'b1) begin
            errs++;
            $display("FAIL tmo_gnt: got %b want 1", f_gnt);
        end
        nx();
        mem_gnt = 1'b0; f_req = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            nx();
            vec++;
            if (f_rvalid !== 1'b0) begin
                errs++;
                $display("FAIL tmo_early[%0d]: got v=%b want 0", c, f_rvalid);
            end
        end
        nx();
        vec++;
        if ({f_rvalid, f_err, f_rdata} !== {2'b11, 32'h0}) begin
            errs++;
            $display("FAIL tmo_resp: got v=%b e=%b rd=%h want 1 1 0", f_rvalid, f_err, f_rdata);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        nx();
        mem_rvalid = 1'b0;
        vec++;
        if ({f_rvalid, d_rvalid, f_rdata} !== {2'b00, 32'h0}) begin
            errs++;
            $display("FAIL tmo_late: got fv=%b dv=%b rd=%h want 0 0 0",
                     f_rvalid, d_rvalid, f_rdata);
        end
        d_req = 1'b1; d_addr = 32'h500;
        nx();
        for (int c = 1; c <= 5; c++) begin
            vec++;
            if ({mem_req, d_gnt, d_rvalid} !== 3'b100) begin
                errs++;
                $display("FAIL tmo_req[%0d]: got req=%b gnt=%b v=%b want 100",
                         c, mem_req, d_gnt, d_rvalid);
            end
            nx();
        end
        d_req = 1'b0;
        vec++;
        if ({d_rvalid, d_err, d_rdata, mem_req} !== {2'b11, 32'h0, 1'b0}) begin
            errs++;
            $display("FAIL tmo_req_resp: got v=%b e=%b rd=%h req=%b want 1 1 0 0",
                     d_rvalid, d_err, d_rdata, mem_req);
        end
        nx();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_addr = 32'h600;
        nx();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #1;
        vec++;
        if (d_gnt !== 1'b1) begin
            errs++;
            $display("FAIL zl_gnt: got %b want 1", d_gnt);
        end
        nx();
        d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        vec++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h77}) begin
            errs++;
            $display("FAIL zl_resp: got v=%b rd=%h want 1 77", d_rvalid, d_rdata);
        end
        f_req = 1'b1; f_addr = 32'h400;
        nx();
        mem_gnt = 1'b1;
        nx();
        mem_gnt = 1'b0; f_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h88;
        #2 rst = 1'b1;
        #1;
        vec++;
        if ({mem_req, mem_addr, f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err} !== 39'h0
            || {f_rdata, d_rdata} !== 64'h0) begin
            errs++;
            $display("FAIL rst_async: got req=%b fv=%b frd=%h drd=%h want all 0",
                     mem_req, f_rvalid, f_rdata, d_rdata);
        end
        nx();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nx();
            vec++;
            if ({f_rvalid, d_rvalid, mem_req} !== 3'b000) begin
                errs++;
                $display("FAIL rst_stale[%0d]: got fv=%b dv=%b req=%b want 000",
                         c, f_rvalid, d_rvalid, mem_req);
            end
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_write();
        test_single_fetch();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/rv32e_mem_arbiter.md
RV32E_MEM_ARBITER -- requirements
Module: rv32e_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles from mem_req assertion to mem_rvalid before an error response is returned.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: f_req  input  1  fetch read request; held with f_addr until f_gnt.
REQ-005 Port: f_addr  input  32  fetch word address.
REQ-006 Port: f_gnt / f_rvalid / f_err  output  1 each  fetch accept pulse / response pulse / error flag, qualified by f_rvalid.
REQ-007 Port: f_rdata  output  32  fetch read data.
REQ-008 Port: d_req, d_we  input  1 each  data request, write enable; held with d_addr, d_wdata and d_be until d_gnt.
REQ-009 Port: d_addr, d_wdata  input  32 each; d_be  input  4  byte enables.
REQ-010 Port: d_gnt / d_rvalid / d_err  output  1 each; d_rdata  output  32  (same semantics as the fetch port).
REQ-011 Port: mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32 each; mem_be  output  4  shared memory request.
REQ-012 Port: mem_gnt, mem_rvalid  input  1 each; mem_rdata  input  32  memory accept and response.

Function
REQ-013 FSM states: IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-014 IDLE: if any x_req is high, latch the winner's addr/we/wdata/be into internal registers and go to REQ; otherwise stay in IDLE.
REQ-015 Arbitration: single requester wins; if both request, the port not granted last wins; the last-grant register updates on each IDLE decision.
REQ-016 Fetch transactions drive mem_we=0 and mem_be=4'hF; fetch ignores d_wdata.
REQ-017 REQ: mem_req=1 with the latched fields, held stable; on mem_gnt=1 pulse the winner's x_gnt for exactly that cycle and go to RESP.
REQ-018 mem_gnt and mem_rvalid high in the same REQ cycle: the response is taken in that cycle and the FSM returns to IDLE, bypassing RESP.
REQ-019 RESP: mem_req=0; on mem_rvalid=1 capture mem_rdata and return to IDLE.
REQ-020 Response outputs are registered: x_rvalid pulses for one cycle in the cycle after mem_rvalid, with x_rdata=mem_rdata and x_err=0.
REQ-021 Writes also receive an x_rvalid acknowledge, with x_rdata=0.
REQ-022 The non-winning port's gnt, rvalid and err stay 0; its rdata holds its previous value.
REQ-023 Timeout counter: cleared on entering REQ; increments every cycle in REQ and RESP.
REQ-024 On reaching TIMEOUT with no response: pulse x_rvalid with x_err=1 and x_rdata=0 the next cycle, then go to IDLE. If a REQ-state timeout occurs, x_gnt is never pulsed.
REQ-025 mem_rvalid received in IDLE (for example, late after a timeout) is ignored; no x_rvalid is produced.
REQ-026 A requester may deassert x_req only after its x_gnt.
REQ-027 Minimum spacing: 3 cycles per transaction (IDLE, REQ, RESP); 2 cycles when REQ-018 applies.

Reset
REQ-028 While rst=1, and asynchronously on its assertion (including mid-transaction):
- state=IDLE
- all mem_* outputs=0
- all gnt/rvalid/err=0
- f_rdata and d_rdata=0
- timeout counter=0
- last-grant=fetch, so data wins the first contention
REQ-029 After rst deasserts, the first arbitration occurs in the first clock edge with rst=0; a transaction in flight at reset is abandoned with no response.

Verification
REQ-030 Single fetch: f_req, f_addr=0x100; mem_gnt after 1 cycle, mem_rvalid with 0x00A00093 two cycles later -> f_gnt pulse, then f_rvalid=1, f_rdata=0x00A00093, f_err=0.
REQ-031 Contention: f_req and d_req both high from reset -> data granted first, then fetch; hold both high -> grants alternate D,F,D,F.
REQ-032 Data write: d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D, d_be=4'b0011 -> mem_* carry exactly these values while mem_req=1; d_rvalid=1, d_rdata=0.
REQ-033 Zero-latency memory: mem_gnt and mem_rvalid in the same cycle -> rvalid the next cycle; back-to-back transactions spaced 2 cycles.
REQ-034 Timeout: TIMEOUT=4, mem_gnt with no mem_rvalid -> x_rvalid=1, x_err=1 at count 4; a late mem_rvalid in IDLE is ignored.
REQ-035 Reset mid-RESP: assert rst between edges -> mem_req and all outputs go to 0 immediately; after release no stale rvalid appears.
